sme_job_sequencer: RTL and testbench

//  Front-end controller for the string-matching engine (SME). Buffers one string (<=32 chars) and up to
//  PAT_SLOTS patterns from a host, streams string then each pattern into SME, waits for each result and

---
 rtl/sme_job_sequencer_if.sv | 40 ++++
 rtl/sme_job_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_sme_job_sequencer.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sme_job_sequencer_if.sv
// Host, result and SME-side signals of the SME job sequencer.
// master: host/SME environment view; slave: the sequencer itself.
interface sme_job_sequencer_if;
    logic       host_wr;
    logic       host_sel;
    logic       host_last;
    logic [7:0] host_data;
    logic       host_clr;
    logic       start;
    logic       host_ready;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_id;
    logic       res_match;
    logic [4:0] res_index;
    logic       res_timeout;
    logic [7:0] sme_chardata;
    logic       sme_isstring;
    logic       sme_ispattern;
    logic       sme_valid;
    logic       sme_match;
    logic [4:0] sme_match_index;

    modport master (
        output host_wr, host_sel, host_last, host_data, host_clr, start, res_ready,
               sme_valid, sme_match, sme_match_index,
        input  host_ready, busy, done, ovf, res_valid, res_id, res_match, res_index,
               res_timeout, sme_chardata, sme_isstring, sme_ispattern
    );

    modport slave (
        input  host_wr, host_sel, host_last, host_data, host_clr, start, res_ready,
               sme_valid, sme_match, sme_match_index,
        output host_ready, busy, done, ovf, res_valid, res_id, res_match, res_index,
               res_timeout, sme_chardata, sme_isstring, sme_ispattern
    );
endinterface

// File: rtl/sme_job_sequencer.sv
// SME job sequencer: buffers one string and up to PAT_SLOTS patterns, streams
// string then each pattern into the SME, collects one result per pattern with a
// watchdog, and hands results to the host over a ready/valid port.
module sme_job_sequencer #(
    parameter int unsigned STR_DEPTH = 32,
    parameter int unsigned PAT_LEN   = 8,
    parameter int unsigned PAT_SLOTS = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    sme_job_sequencer_if.slave bus
);
    localparam int unsigned SW = $clog2(STR_DEPTH + 1);
    localparam int unsigned PW = $clog2(PAT_LEN + 1);
    localparam int unsigned CW = $clog2(PAT_SLOTS + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam int unsigned SI = $clog2(STR_DEPTH);
    localparam int unsigned LI = $clog2(PAT_LEN);
    localparam int unsigned IW = $clog2(PAT_SLOTS);
    localparam int unsigned KW = (SW > PW) ? SW : PW;

    typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT_RES, REPORT} state_t;
    state_t state, state_nx;

    logic [7:0]    sbuf  [STR_DEPTH];
    logic [7:0]    pbuf  [PAT_SLOTS][PAT_LEN];
    logic [PW-1:0] plens [PAT_SLOTS];

    logic [SW-1:0] str_len;
    logic [CW-1:0] pat_cnt, p;
    logic [PW-1:0] plen, plen_after;
    logic [KW-1:0] k;
    logic [WW-1:0] wd;
    logic          resend, done_q, ovf_q, res_match_q, res_timeout_q;
    logic [4:0]    res_index_q;

    logic          clr_acc, start_acc, wr_acc, str_full, pat_full, str_we, pat_we;
    logic          byte_drop, slot_close, job_ok, str_end, pat_end, wd_exp, last_res;
    logic [IW-1:0] p_idx, slot_idx;
    logic [7:0]    chardata;
    logic          isstring, ispattern;

    // Host-side accept/drop decode; clear beats start, start beats a write.
    always_comb begin
        clr_acc    = (state == IDLE) && bus.host_clr;
        start_acc  = (state == IDLE) && bus.start && !bus.host_clr;
        wr_acc     = (state == IDLE) && bus.host_wr && !bus.host_clr && !bus.start;
        str_full   = (str_len == SW'(STR_DEPTH));
        pat_full   = (pat_cnt == CW'(PAT_SLOTS)) || (plen == PW'(PAT_LEN));
        str_we     = wr_acc && !bus.host_sel && !str_full;
        pat_we     = wr_acc && bus.host_sel && !pat_full;
        byte_drop  = wr_acc && (bus.host_sel ? pat_full : str_full);
        plen_after = pat_we ? plen + 1'b1 : plen;
        // An open slot is closed by host_last or implicitly by start.
        slot_close = (plen_after != '0) &&
                     ((wr_acc && bus.host_sel && bus.host_last) || start_acc);
        job_ok     = (str_len != '0) && ((pat_cnt != '0) || (plen != '0));
        p_idx      = p[IW-1:0];
        slot_idx   = pat_cnt[IW-1:0];
        str_end    = (k == KW'(str_len) - 1'b1);
        pat_end    = (k == KW'(plens[p_idx]) - 1'b1);
        wd_exp     = (wd == WW'(TIMEOUT - 1));
        last_res   = ((p + 1'b1) == pat_cnt);
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state and SME streaming outputs.
    always_comb begin
        state_nx  = state;
        isstring  = 1'b0;
        ispattern = 1'b0;
        chardata  = '0;
        case (state)
            IDLE:     if (start_acc && job_ok) state_nx = SEND_STR;
            SEND_STR: begin
                isstring = 1'b1;
                chardata = sbuf[k[SI-1:0]];
                if (str_end) state_nx = SEND_PAT;
            end
            SEND_PAT: begin
                ispattern = 1'b1;
                chardata  = pbuf[p_idx][k[LI-1:0]];
                if (pat_end) state_nx = WAIT_RES;
            end
            WAIT_RES: if (bus.sme_valid || wd_exp) state_nx = REPORT;
            REPORT: begin
                if (bus.res_ready) begin
                    if (last_res)    state_nx = IDLE;
                    else if (resend) state_nx = SEND_STR;
                    else             state_nx = SEND_PAT;
                end
            end
            default:  state_nx = IDLE;
        endcase
    end

    // Buffer storage; contents survive reset and are reused on restart.
    always_ff @(posedge clk) begin
        if (str_we)     sbuf[str_len[SI-1:0]] <= bus.host_data;
        if (pat_we)     pbuf[slot_idx][plen[LI-1:0]] <= bus.host_data;
        if (slot_close) plens[slot_idx] <= plen_after;
    end

    // Counters, watchdog, result capture and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            str_len       <= '0;
            pat_cnt       <= '0;
            plen          <= '0;
            p             <= '0;
            k             <= '0;
            wd            <= '0;
            resend        <= 1'b0;
            done_q        <= 1'b0;
            ovf_q         <= 1'b0;
            res_match_q   <= 1'b0;
            res_index_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clr_acc) begin
                str_len <= '0;
                pat_cnt <= '0;
                plen    <= '0;
                ovf_q   <= 1'b0;
                done_q  <= bus.start;
            end else begin
                if (str_we)     str_len <= str_len + 1'b1;
                if (byte_drop)  ovf_q   <= 1'b1;
                if (slot_close) begin
                    pat_cnt <= pat_cnt + 1'b1;
                    plen    <= '0;
                end else if (pat_we) begin
                    plen    <= plen_after;
                end
                if (start_acc) begin
                    k      <= '0;
                    p      <= '0;
                    resend <= 1'b0;
                    done_q <= !job_ok;
                end
            end
            case (state)
                SEND_STR: k <= str_end ? '0 : k + 1'b1;
                SEND_PAT: begin
                    k  <= pat_end ? '0 : k + 1'b1;
                    wd <= '0;
                end
                WAIT_RES: begin
                    if (bus.sme_valid) begin
                        res_match_q   <= bus.sme_match;
                        res_index_q   <= bus.sme_match_index;
                        res_timeout_q <= 1'b0;
                    end else if (wd_exp) begin
                        res_match_q   <= 1'b0;
                        res_index_q   <= '0;
                        res_timeout_q <= 1'b1;
                        resend        <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                REPORT: begin
                    if (bus.res_ready) begin
                        p <= p + 1'b1;
                        if (last_res)    done_q <= 1'b1;
                        else if (resend) resend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.host_ready    = (state == IDLE);
    assign bus.busy          = (state != IDLE);
    assign bus.done          = done_q;
    assign bus.ovf           = ovf_q;
    assign bus.res_valid     = (state == REPORT);
    assign bus.res_id        = 2'(p);
    assign bus.res_match     = res_match_q;
    assign bus.res_index     = res_index_q;
    assign bus.res_timeout   = res_timeout_q;
    assign bus.sme_chardata  = chardata;
    assign bus.sme_isstring  = isstring;
    assign bus.sme_ispattern = ispattern;
endmodule

// File: tb/tb_sme_job_sequencer.sv
// Self-checking bench for sme_job_sequencer: scoreboard of expected SME bytes and
// host results, a scripted SME responder, and one task per scenario.
module tb_sme_job_sequencer;
    logic clk = 1'b0;
    logic reset_n;

    sme_job_sequencer_if bus ();

    sme_job_sequencer #(
        .STR_DEPTH(32),
        .PAT_LEN  (8),
        .PAT_SLOTS(4),
        .TIMEOUT  (255)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic s; logic [7:0] d; } byte_t;
    typedef struct packed { logic [1:0] id; logic m; logic [4:0] idx; logic t; } res_t;
    typedef struct { bit never; int delay; logic m; logic [4:0] idx; } resp_t;

    byte_t exp_bytes[$];
    res_t  exp_res[$];
    resp_t resp_q[$];

    int    vectors = 0;
    int    miscompares = 0;
    int    str_cyc = 0;
    int    pat_cyc = 0;
    bit    mon_en = 1'b0;
    bit    prev_pat = 1'b0;
    byte_t mb;
    res_t  mr;
    resp_t rr;

    // Scoreboard: every SME byte and every result handshake is popped and compared.
    always @(negedge clk) begin
        if (mon_en && reset_n === 1'b1) begin
            if (bus.sme_isstring === 1'b1) str_cyc++;
            if (bus.sme_ispattern === 1'b1) pat_cyc++;
            if (bus.sme_isstring === 1'b1 || bus.sme_ispattern === 1'b1) begin
                vectors++;
                if (exp_bytes.size() == 0) begin
                    miscompares++;
                    $display("FAIL sme_byte: got isstr=%0b ispat=%0b data=%02h, required no SME byte",
                             bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata);
                end else begin
                    mb = exp_bytes.pop_front();
                    if ({bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata} !== {mb.s, !mb.s, mb.d}) begin
                        miscompares++;
                        $display("FAIL sme_byte: got isstr=%0b ispat=%0b data=%02h, required isstr=%0b ispat=%0b data=%02h",
                                 bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata, mb.s, !mb.s, mb.d);
                    end
                end
            end
            if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
                vectors++;
                if (exp_res.size() == 0) begin
                    miscompares++;
                    $display("FAIL result: got id=%0d m=%0b idx=%0d t=%0b, required no result",
                             bus.res_id, bus.res_match, bus.res_index, bus.res_timeout);
                end else begin
                    mr = exp_res.pop_front();
                    if ({bus.res_id, bus.res_match, bus.res_index, bus.res_timeout} !== mr) begin
                        miscompares++;
                        $display("FAIL result: got id=%0d m=%0b idx=%0d t=%0b, required id=%0d m=%0b idx=%0d t=%0b",
                                 bus.res_id, bus.res_match, bus.res_index, bus.res_timeout,
                                 mr.id, mr.m, mr.idx, mr.t);
                    end
                end
            end
        end
    end

    // SME model: after each pattern ends, answer per the next scripted response.
    initial begin
        bus.sme_valid = 1'b0;
        bus.sme_match = 1'b0;
        bus.sme_match_index = '0;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && prev_pat && bus.sme_ispattern === 1'b0 && resp_q.size() != 0) begin
                rr = resp_q.pop_front();
                if (!rr.never) begin
                    repeat (rr.delay) @(negedge clk);
                    bus.sme_match = rr.m;
                    bus.sme_match_index = rr.idx;
                    bus.sme_valid = 1'b1;
                    @(negedge clk);
                    bus.sme_valid = 1'b0;
                end
            end
            prev_pat = (bus.sme_ispattern === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic sel, input logic last, input logic [7:0] data);
        bus.host_wr = 1'b1;
        bus.host_sel = sel;
        bus.host_last = last;
        bus.host_data = data;
        tick();
        bus.host_wr = 1'b0;
        bus.host_last = 1'b0;
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) wr_byte(1'b0, 1'b0, s[i]);
    endtask

    task automatic load_pat(input string s);
        for (int i = 0; i < s.len(); i++) wr_byte(1'b1, i == s.len() - 1, s[i]);
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_bytes.push_back({1'b1, 8'(s[i])});
    endtask

    task automatic push_pat(input string s);
        for (int i = 0; i < s.len() && i < 8; i++) exp_bytes.push_back({1'b0, 8'(s[i])});
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_clr();
        bus.host_clr = 1'b1;
        tick();
        bus.host_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({bus.host_ready, bus.busy, bus.done, bus.ovf, bus.res_valid, bus.sme_isstring,
             bus.sme_ispattern, bus.res_timeout, bus.res_match} !== 9'b100000000) begin
            miscompares++;
            $display("FAIL reset_flags: got rdy=%0b busy=%0b done=%0b ovf=%0b rv=%0b isstr=%0b ispat=%0b, required rdy=1 others 0",
                     bus.host_ready, bus.busy, bus.done, bus.ovf, bus.res_valid, bus.sme_isstring, bus.sme_ispattern);
        end
        vectors++;
        if ({bus.sme_chardata, bus.res_id, bus.res_index} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_data: got data=%02h id=%0d idx=%0d, required 0 0 0",
                     bus.sme_chardata, bus.res_id, bus.res_index);
        end
        reset_n = 1'b1;
        mon_en = 1'b1;
        tick();
        vectors++;
        if ({bus.host_ready, bus.busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_release: got rdy=%0b busy=%0b, required 1 0", bus.host_ready, bus.busy);
        end
    endtask

    task automatic test_single();
        int n;
        do_clr();
        load_str("hello world");
        load_pat("wor");
        push_str("hello world");
        push_pat("wor");
        resp_q.push_back('{1'b0, 2, 1'b1, 5'd6});
        exp_res.push_back('{2'd0, 1'b1, 5'd6, 1'b0});
        str_cyc = 0;
        pat_cyc = 0;
        do_start();
        for (int c = 0; c < 14; c++) begin
            vectors++;
            if ({bus.sme_isstring, bus.sme_ispattern} !== ((c < 11) ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL t1_stream_cycle%0d: got isstr=%0b ispat=%0b, required %0b", c,
                         bus.sme_isstring, bus.sme_ispattern, (c < 11) ? 2'b10 : 2'b01);
            end
            tick();
        end
        vectors++;
        if ({bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata, bus.busy} !== {2'b00, 8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL t1_wait_idle_bus: got isstr=%0b ispat=%0b data=%02h busy=%0b, required 0 0 00 1",
                     bus.sme_isstring, bus.sme_ispattern, bus.sme_chardata, bus.busy);
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 60) begin tick(); n++; end
        vectors++;
        if (bus.done !== 1'b1) begin
            miscompares++;
            $display("FAIL t1_done: got done=%0b after %0d cycles, required 1", bus.done, n);
        end
        vectors++;
        if (str_cyc != 11 || pat_cyc != 3 || exp_bytes.size() != 0 || exp_res.size() != 0) begin
            miscompares++;
            $display("FAIL t1_counts: got str=%0d pat=%0d pending bytes=%0d res=%0d, required 11 3 0 0",
                     str_cyc, pat_cyc, exp_bytes.size(), exp_res.size());
        end
    endtask

    task automatic test_multi_pattern();
        int n;
        do_clr();
        load_str("hello world");
        load_pat("^he");
        load_pat("d$");
        load_pat("xyz");
        push_str("hello world");
        push_pat("^he");
        push_pat("d$");
        push_pat("xyz");
        resp_q.push_back('{1'b0, 1, 1'b1, 5'd0});
        resp_q.push_back('{1'b0, 0, 1'b1, 5'd10});
        resp_q.push_back('{1'b0, 3, 1'b0, 5'd0});
        exp_res.push_back('{2'd0, 1'b1, 5'd0, 1'b0});
        exp_res.push_back('{2'd1, 1'b1, 5'd10, 1'b0});
        exp_res.push_back('{2'd2, 1'b0, 5'd0, 1'b0});
        str_cyc = 0;
        bus.res_ready = 1'b0;
        do_start();
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (bus.res_valid !== 1'b1 && n < 60) begin tick(); n++; end
            for (int c = 0; c < 5; c++) begin
                vectors++;
                if ({bus.res_valid, bus.res_id} !== {1'b1, 2'(r)}) begin
                    miscompares++;
                    $display("FAIL t2_hold_r%0d_c%0d: got valid=%0b id=%0d, required 1 %0d",
                             r, c, bus.res_valid, bus.res_id, r);
                end
                tick();
            end
            bus.res_ready = 1'b1;
            tick();
            bus.res_ready = 1'b0;
        end
        vectors++;
        if (bus.done !== 1'b1) begin
            miscompares++;
            $display("FAIL t2_done: got done=%0b after third handshake, required 1", bus.done);
        end
        tick();
        vectors++;
        if (bus.done !== 1'b0 || str_cyc != 11 || exp_bytes.size() != 0) begin
            miscompares++;
            $display("FAIL t2_pulse_once: got done=%0b str=%0d pending=%0d, required 0 11 0",
                     bus.done, str_cyc, exp_bytes.size());
        end
        bus.res_ready = 1'b1;
    endtask

    task automatic test_overflow();
        int n;
        do_clr();
        for (int i = 0; i < 9; i++) begin
            wr_byte(1'b1, 1'b0, 8'h10);
            if (i == 7 || i == 8) begin
                vectors++;
                if (bus.ovf !== (i == 8)) begin
                    miscompares++;
                    $display("FAIL t3_pat_bytes_%0d: got ovf=%0b, required %0b", i + 1, bus.ovf, i == 8);
                end
            end
        end
        do_clr();
        for (int i = 0; i < 5; i++) begin
            wr_byte(1'b1, 1'b1, 8'h20);
            if (i >= 3) begin
                vectors++;
                if (bus.ovf !== (i == 4)) begin
                    miscompares++;
                    $display("FAIL t3_slot_%0d: got ovf=%0b, required %0b", i + 1, bus.ovf, i == 4);
                end
            end
        end
        do_clr();
        for (int i = 0; i < 34; i++) begin
            wr_byte(1'b0, 1'b0, 8'(8'h40 + i));
            if (i == 31 || i == 33) begin
                vectors++;
                if (bus.ovf !== (i == 33)) begin
                    miscompares++;
                    $display("FAIL t3_str_bytes_%0d: got ovf=%0b, required %0b", i + 1, bus.ovf, i == 33);
                end
            end
            if (i < 32) exp_bytes.push_back({1'b1, 8'(8'h40 + i)});
        end
        for (int i = 0; i < 9; i++) begin
            wr_byte(1'b1, i == 8, 8'(8'h80 + i));
            if (i < 8) exp_bytes.push_back({1'b0, 8'(8'h80 + i)});
        end
        load_pat("A");
        load_pat("B");
        load_pat("C");
        load_pat("Z");
        push_pat("A");
        push_pat("B");
        push_pat("C");
        for (int s = 0; s < 4; s++) begin
            resp_q.push_back('{1'b0, 0, 1'b1, 5'(s + 1)});
            exp_res.push_back('{2'(s), 1'b1, 5'(s + 1), 1'b0});
        end
        do_start();
        n = 0;
        while (bus.done !== 1'b1 && n < 300) begin tick(); n++; end
        vectors++;
        if (bus.done !== 1'b1 || bus.ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL t3_done: got done=%0b ovf=%0b after %0d cycles, required 1 1", bus.done, bus.ovf, n);
        end
        vectors++;
        if (exp_bytes.size() != 0 || exp_res.size() != 0) begin
            miscompares++;
            $display("FAIL t3_pending: got bytes=%0d res=%0d, required 0 0", exp_bytes.size(), exp_res.size());
        end
    endtask

    task automatic test_timeout();
        int n;
        do_clr();
        load_str("abcd");
        load_pat("ab");
        load_pat("cd");
        push_str("abcd");
        push_pat("ab");
        push_str("abcd");
        push_pat("cd");
        resp_q.push_back('{1'b1, 0, 1'b0, 5'd0});
        resp_q.push_back('{1'b0, 1, 1'b1, 5'd2});
        exp_res.push_back('{2'd0, 1'b0, 5'd0, 1'b1});
        exp_res.push_back('{2'd1, 1'b1, 5'd2, 1'b0});
        str_cyc = 0;
        pat_cyc = 0;
        do_start();
        n = 0;
        while (bus.sme_ispattern !== 1'b1 && n < 20) begin tick(); n++; end
        while (bus.sme_ispattern === 1'b1 && n < 40) begin tick(); n++; end
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 400) begin tick(); n++; end
        vectors++;
        if (n != 255) begin
            miscompares++;
            $display("FAIL t4_wait_cycles: got %0d cycles in WAIT_RES, required 255", n);
        end
        vectors++;
        if ({bus.res_valid, bus.res_timeout, bus.res_match, bus.res_index} !== {3'b110, 5'd0}) begin
            miscompares++;
            $display("FAIL t4_timeout_flags: got valid=%0b t=%0b m=%0b idx=%0d, required 1 1 0 0",
                     bus.res_valid, bus.res_timeout, bus.res_match, bus.res_index);
        end
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin tick(); n++; end
        vectors++;
        if (bus.done !== 1'b1 || str_cyc != 8 || pat_cyc != 4) begin
            miscompares++;
            $display("FAIL t4_resend: got done=%0b str=%0d pat=%0d, required 1 8 4", bus.done, str_cyc, pat_cyc);
        end
        vectors++;
        if (exp_bytes.size() != 0 || exp_res.size() != 0) begin
            miscompares++;
            $display("FAIL t4_pending: got bytes=%0d res=%0d, required 0 0", exp_bytes.size(), exp_res.size());
        end
    endtask

    task automatic test_empty_start();
        do_clr();
        load_str("xy");
        str_cyc = 0;
        pat_cyc = 0;
        do_start();
        vectors++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL t5_no_pat_done: got done=%0b busy=%0b, required 1 0", bus.done, bus.busy);
        end
        tick();
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL t5_pulse: got done=%0b one cycle later, required 0", bus.done);
        end
        load_pat("q");
        wr_byte(1'b1, 1'b0, 8'h71);
        do_clr();
        do_start();
        vectors++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL t5_clr_done: got done=%0b busy=%0b, required 1 0", bus.done, bus.busy);
        end
        tick();
        tick();
        vectors++;
        if (str_cyc != 0 || pat_cyc != 0) begin
            miscompares++;
            $display("FAIL t5_no_sme: got str=%0d pat=%0d cycles, required 0 0", str_cyc, pat_cyc);
        end
    endtask

    task automatic test_reset_mid_job();
        do_clr();
        load_str("abc");
        load_pat("defghijkl");
        vectors++;
        if (bus.ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL t6_ovf_pre: got ovf=%0b, required 1", bus.ovf);
        end
        push_str("abc");
        exp_bytes.push_back({1'b0, 8'h64});
        resp_q.push_back('{1'b1, 0, 1'b0, 5'd0});
        do_start();
        repeat (4) tick();
        vectors++;
        if (bus.sme_ispattern !== 1'b1) begin
            miscompares++;
            $display("FAIL t6_in_pat: got ispat=%0b, required 1", bus.sme_ispattern);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.sme_ispattern, bus.sme_isstring, bus.busy, bus.host_ready, bus.ovf} !== 5'b00010) begin
            miscompares++;
            $display("FAIL t6_async: got ispat=%0b isstr=%0b busy=%0b rdy=%0b ovf=%0b, required 0 0 0 1 0",
                     bus.sme_ispattern, bus.sme_isstring, bus.busy, bus.host_ready, bus.ovf);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if ({bus.done, bus.res_valid} !== 2'b00) begin
                miscompares++;
                $display("FAIL t6_quiet_c%0d: got done=%0b res_valid=%0b, required 0 0", c, bus.done, bus.res_valid);
            end
        end
        reset_n = 1'b1;
        tick();
        vectors++;
        if ({bus.done, bus.busy, bus.host_ready} !== 3'b001 || exp_bytes.size() != 0) begin
            miscompares++;
            $display("FAIL t6_after: got done=%0b busy=%0b rdy=%0b pending=%0d, required 0 0 1 0",
                     bus.done, bus.busy, bus.host_ready, exp_bytes.size());
        end
        resp_q.delete();
    endtask

    initial begin
        bus.host_wr   = 1'b0;
        bus.host_sel  = 1'b0;
        bus.host_last = 1'b0;
        bus.host_data = '0;
        bus.host_clr  = 1'b0;
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        test_reset();
        test_single();
        test_multi_pattern();
        test_overflow();
        test_timeout();
        test_empty_start();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
